// File: rtl/trainer.sv
// rtl/trainer.sv - sample-table neuron trainer: drives training epochs, then one evaluation pass
//
// Optional feature macro: TRAINER_EARLY_STOP_EN
//   When defined, a training epoch with all-zero errors ends training early.
//
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   smp_stb/smp_rdy/smp_dat        sample load {tgt[7:0], arg[N-1:0][7:0]}
//   clr, start                     one-cycle pulses: empty table / begin a run
//   en                             neuron training enable
//   arg_stb/arg_rdy/arg_dat        argument to the neuron
//   res_stb/res_rdy/res_dat        neuron result
//   err_stb/err_rdy/err_dat        signed error (tgt - res) back to the neuron
//   fbk_stb/fbk_rdy/fbk_dat        neuron feedback, accepted and discarded
//   busy, done, pass, epoch        run status

module trainer #(
    parameter int N      = 2,
    parameter int S      = 4,
    parameter int EPOCHS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             smp_stb,
    output logic             smp_rdy,
    input  logic [8*N+7:0]   smp_dat,
    input  logic             clr,
    input  logic             start,
    output logic             en,
    output logic             arg_stb,
    input  logic             arg_rdy,
    output logic [8*N-1:0]   arg_dat,
    input  logic             res_stb,
    output logic             res_rdy,
    input  logic [7:0]       res_dat,
    output logic             err_stb,
    input  logic             err_rdy,
    output logic [15:0]      err_dat,
    input  logic             fbk_stb,
    output logic             fbk_rdy,
    input  logic [16*N-1:0]  fbk_dat,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       epoch
);

    localparam int IW = (S > 1) ? $clog2(S) : 1;
    localparam int CW = $clog2(S + 1);

`ifdef TRAINER_EARLY_STOP_EN
    localparam bit EARLY_STOP = 1'b1;
`else
    localparam bit EARLY_STOP = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, ARG, RES, ERR, FBK, EVAL_ARG, EVAL_RES, DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [IW-1:0]  index_q, index_d;
    logic [7:0]     epoch_q, epoch_d;
    logic [15:0]    err_q, err_d;
    logic           done_q, done_d;
    logic           pass_q, pass_d;
    logic           flag_q, flag_d;     // evaluation: no nonzero error seen yet
    logic           clean_q, clean_d;   // training: current epoch all-zero so far
    logic           launch;

    logic [8*N+7:0] table_q [S];
    logic [8*N+7:0] cur_smp;
    logic [8:0]     diff;
    logic           last_smp;
    logic           last_epoch;
    logic           fbk_unused;

    // Feedback content has no use here; it is only handshaken away.
    assign fbk_unused = ^fbk_dat;

    assign cur_smp    = table_q[index_q];
    assign arg_dat    = cur_smp[8*N-1:0];
    assign diff       = {1'b0, cur_smp[8*N +: 8]} - {1'b0, res_dat};
    assign last_smp   = (32'(index_q) + 32'd1 >= 32'(count_q));
    assign last_epoch = (32'(epoch_q) + 32'd1 >= 32'(EPOCHS));

    // Handshake outputs are pure state decodes; smp_rdy is also gated by rst
    // so nothing advertises readiness while reset is held.
    assign smp_rdy = rst && (state_q == IDLE) && (count_q < CW'(S));
    assign arg_stb = (state_q == ARG) || (state_q == EVAL_ARG);
    assign res_rdy = (state_q == RES) || (state_q == EVAL_RES);
    assign err_stb = (state_q == ERR);
    assign fbk_rdy = (state_q == FBK);
    assign en      = (state_q == ARG) || (state_q == RES) ||
                     (state_q == ERR) || (state_q == FBK);
    assign busy    = (state_q != IDLE) && (state_q != DONE);
    assign done    = done_q;
    assign pass    = done_q && pass_q;
    assign epoch   = epoch_q;
    assign err_dat = err_q;

    // Table contents are not reset.
    always_ff @(posedge clk) begin
        if (smp_stb && smp_rdy && !clr)
            table_q[count_q[IW-1:0]] <= smp_dat;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            index_q <= '0;
            epoch_q <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            flag_q  <= 1'b0;
            clean_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            index_q <= index_d;
            epoch_q <= epoch_d;
            err_q   <= err_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            flag_q  <= flag_d;
            clean_q <= clean_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        epoch_d = epoch_q;
        err_d   = err_q;
        done_d  = done_q;
        pass_d  = pass_q;
        flag_d  = flag_q;
        clean_d = clean_q;
        launch  = 1'b0;

        case (state_q)
            IDLE: begin
                if (clr) begin
                    count_d = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end else begin
                    if (smp_stb && smp_rdy)
                        count_d = count_q + 1'b1;
                    launch = start;
                end
            end
            ARG: begin
                if (arg_rdy)
                    state_d = RES;
            end
            RES: begin
                if (res_stb) begin
                    err_d   = {{7{diff[8]}}, diff};
                    state_d = ERR;
                    if (diff != 9'd0)
                        clean_d = 1'b0;
                end
            end
            ERR: begin
                if (err_rdy)
                    state_d = FBK;
            end
            FBK: begin
                if (fbk_stb) begin
                    if (!last_smp) begin
                        index_d = index_q + 1'b1;
                        state_d = ARG;
                    end else begin
                        index_d = '0;
                        if (last_epoch || (EARLY_STOP && clean_q)) begin
                            flag_d  = 1'b1;
                            state_d = EVAL_ARG;
                        end else begin
                            epoch_d = epoch_q + 8'd1;
                            clean_d = 1'b1;
                            state_d = ARG;
                        end
                    end
                end
            end
            EVAL_ARG: begin
                if (arg_rdy)
                    state_d = EVAL_RES;
            end
            EVAL_RES: begin
                if (res_stb) begin
                    err_d = {{7{diff[8]}}, diff};
                    if (diff != 9'd0)
                        flag_d = 1'b0;
                    if (!last_smp) begin
                        index_d = index_q + 1'b1;
                        state_d = EVAL_ARG;
                    end else begin
                        index_d = '0;
                        done_d  = 1'b1;
                        pass_d  = flag_q && (diff == 9'd0);
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // DONE lasts one cycle; done/pass stay latched in IDLE so
                // the table can be reloaded or cleared afterwards.
                state_d = IDLE;
                launch  = start;
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            if (count_q == '0) begin
                done_d  = 1'b1;
                pass_d  = 1'b0;
                state_d = DONE;
            end else begin
                index_d = '0;
                epoch_d = '0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
                clean_d = 1'b1;
                state_d = ARG;
            end
        end
    end

endmodule

// File: tb/tb_trainer.sv
// tb/tb_trainer.sv - table-driven bench for trainer with a bench-side neuron model

module tb_trainer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        smp_stb = 1'b0;
    logic        smp_rdy;
    logic [23:0] smp_dat = '0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic        en;
    logic        arg_stb;
    logic        arg_rdy = 1'b0;
    logic [15:0] arg_dat;
    logic        res_stb = 1'b0;
    logic        res_rdy;
    logic [7:0]  res_dat = '0;
    logic        err_stb;
    logic        err_rdy = 1'b0;
    logic [15:0] err_dat;
    logic        fbk_stb = 1'b0;
    logic        fbk_rdy;
    logic [31:0] fbk_dat = '0;
    logic        busy;
    logic        done;
    logic        pass;
    logic [7:0]  epoch;

    always #5 clk = ~clk;

    trainer #(.N(2), .S(4), .EPOCHS(10)) dut (
        .clk(clk), .rst(rst),
        .smp_stb(smp_stb), .smp_rdy(smp_rdy), .smp_dat(smp_dat),
        .clr(clr), .start(start), .en(en),
        .arg_stb(arg_stb), .arg_rdy(arg_rdy), .arg_dat(arg_dat),
        .res_stb(res_stb), .res_rdy(res_rdy), .res_dat(res_dat),
        .err_stb(err_stb), .err_rdy(err_rdy), .err_dat(err_dat),
        .fbk_stb(fbk_stb), .fbk_rdy(fbk_rdy), .fbk_dat(fbk_dat),
        .busy(busy), .done(done), .pass(pass), .epoch(epoch)
    );

`ifdef TRAINER_EARLY_STOP_EN
    localparam int GOOD_ERRS = 4;
`else
    localparam int GOOD_ERRS = 40;
`endif

    typedef struct {
        logic [15:0] arg;
        logic [7:0]  tgt;
        logic [7:0]  bad_res;
        logic [15:0] bad_err;
    } vec_t;

    vec_t vecs [4];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_all();
        for (int i = 0; i < 4; i++) begin
            smp_stb = 1'b1;
            smp_dat = {vecs[i].tgt, vecs[i].arg};
            check("smp_rdy_load", smp_rdy, 1);
            @(negedge clk);
        end
        smp_stb = 1'b0;
        check("smp_rdy_full", smp_rdy, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Starts a run and services the neuron side until done. bad selects the
    // faulty neuron model; abort_epoch >= 0 pulses reset during ERR of that epoch.
    task automatic run(input bit bad, input int stall, input int abort_epoch,
                       input int exp_errs, input bit exp_pass);
        int          arg_cnt = 0, err_cnt = 0, eval_cnt = 0, cyc = 0;
        int          arg_wait = 0, err_wait = 0, k = 0;
        bit          res_pend = 0, fbk_pend = 0, aborted = 0;
        logic [7:0]  res_val = '0;
        logic [15:0] held_arg = '0, held_err = '0;

        pulse_start();
        check("start_busy", busy, 1);
        check("start_en", en, 1);
        check("start_epoch", epoch, 0);
        check("start_done", done, 0);
        check("start_arg_stb", arg_stb, 1);

        while (!done && cyc < 4000) begin
            res_stb = res_pend;
            res_dat = res_val;
            fbk_stb = fbk_pend;
            arg_rdy = 1'b0;
            err_rdy = 1'b0;
            if (arg_stb) begin
                if (arg_wait == 0) begin
                    k = arg_cnt % 4;
                    check("arg_dat", arg_dat, vecs[k].arg);
                    check("arg_en", en, (arg_cnt < exp_errs) ? 1 : 0);
                    held_arg = arg_dat;
                end else begin
                    check("arg_hold", arg_dat, held_arg);
                end
                if (arg_wait >= stall) begin
                    arg_rdy  = 1'b1;
                    arg_wait = 0;
                    if (!en) eval_cnt++;
                    arg_cnt++;
                    res_pend = 1;
                    res_val  = bad ? vecs[k].bad_res : vecs[k].tgt;
                end else begin
                    arg_wait++;
                end
            end
            if (err_stb) begin
                if (abort_epoch >= 0 && int'(epoch) == abort_epoch) begin
                    rst = 1'b0;
                    #1;
                    check("rst_err_stb", err_stb, 0);
                    check("rst_arg_stb", arg_stb, 0);
                    check("rst_res_rdy", res_rdy, 0);
                    check("rst_fbk_rdy", fbk_rdy, 0);
                    check("rst_smp_rdy", smp_rdy, 0);
                    check("rst_en", en, 0);
                    check("rst_busy", busy, 0);
                    check("rst_done", done, 0);
                    check("rst_pass", pass, 0);
                    check("rst_epoch", epoch, 0);
                    check("rst_err_dat", err_dat, 0);
                    aborted = 1;
                    break;
                end
                if (err_wait == 0) begin
                    check("err_dat", err_dat, bad ? vecs[k].bad_err : 16'h0000);
                    held_err = err_dat;
                end else begin
                    check("err_hold", err_dat, held_err);
                end
                if (err_wait >= stall) begin
                    err_rdy  = 1'b1;
                    err_wait = 0;
                    err_cnt++;
                    fbk_pend = 1;
                end else begin
                    err_wait++;
                end
            end
            if (res_stb && res_rdy) res_pend = 0;
            if (fbk_stb && fbk_rdy) fbk_pend = 0;
            @(negedge clk);
            cyc++;
        end

        res_stb = 1'b0;
        fbk_stb = 1'b0;
        arg_rdy = 1'b0;
        err_rdy = 1'b0;

        if (aborted) begin
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check("post_rst_smp_rdy", smp_rdy, 1);
        end else begin
            check("run_done", done, 1);
            check("err_count", err_cnt, exp_errs);
            check("eval_count", eval_cnt, 4);
            check("pass", pass, exp_pass);
            check("done_busy", busy, 0);
            check("done_en", en, 0);
            @(negedge clk);
            check("done_held", done, 1);
        end
    endtask

    initial begin
        vecs[0] = '{16'h0000, 8'h00, 8'hff, 16'hff01};
        vecs[1] = '{16'h00ff, 8'h00, 8'hff, 16'hff01};
        vecs[2] = '{16'hff00, 8'h00, 8'hff, 16'hff01};
        vecs[3] = '{16'hffff, 8'hff, 8'h00, 16'h00ff};

        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_en", en, 0);
        check("reset_smp_rdy", smp_rdy, 0);
        check("reset_err_dat", err_dat, 0);
        check("reset_epoch", epoch, 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_smp_rdy", smp_rdy, 1);

        // Table capacity, clear and empty start
        load_all();
        smp_stb = 1'b1;
        smp_dat = 24'hABCDEF;
        check("fifth_smp_rdy", smp_rdy, 0);
        @(negedge clk);
        smp_stb = 1'b0;
        check("fifth_still_full", smp_rdy, 0);
        pulse_clr();
        check("clr_smp_rdy", smp_rdy, 1);
        pulse_start();
        check("empty_done", done, 1);
        check("empty_pass", pass, 0);
        check("empty_busy", busy, 0);
        @(negedge clk);
        check("empty_done_held", done, 1);
        pulse_clr();
        check("clr_done", done, 0);

        // Perfect neuron
        load_all();
        run(0, 0, -1, GOOD_ERRS, 1);

        // Faulty neuron with stalled arg/err acceptance
        run(1, 5, -1, 40, 0);

        // Reset during ERR of epoch 3, then a fresh load and run
        run(0, 0, 3, 40, 0);
        load_all();
        run(0, 0, -1, GOOD_ERRS, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
